// File: rtl/load_buffer.sv
// load_buffer
//   Holds loads leaving the load-data stage until every requested byte is
//   known. Missing bytes are filled from matching MSHR fills. Finished loads
//   are aligned, sign/zero-extended and offered to the load writeback/CDB port.
//
//   Optional feature macro: LOAD_BUFFER_AGE_ORDER_EN
//     defined   -> an age matrix orders entries; the oldest ready entry wins
//     undefined -> the lowest-index ready entry wins; no age state
//
//   Ports
//     clock, reset (async active-low)
//     load_buffer_packet / load_buffer_free : enqueue side
//     fill_valid, fill_mshr_idx, fill_data  : cache MSHR fill return
//     ld_cdb_req / ld_cdb_gnt               : writeback handshake
//     ld_wb_reg, ld_wb_data, ld_wb_bm       : presented load
//     b_mm_resolve, b_mm_mispred            : branch resolution

package load_buffer_pkg;
  typedef logic [31:0] data_t;
  typedef logic [1:0]  mshr_idx_t;
  typedef logic [5:0]  prn_t;
  typedef logic [3:0]  b_mask_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      is_unsigned;
    mem_size_e size;
  } load_func_t;

  typedef struct packed {
    logic        valid;
    mshr_idx_t   mshr_idx;
    b_mask_t     bm;
    prn_t        dest_reg_idx;
    logic [31:0] load_addr;
    load_func_t  load_func;
    data_t       result;
    logic [3:0]  byte_mask;   // 1 = byte still missing
  } load_buffer_packet_t;
endpackage

module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  load_buffer_packet_t load_buffer_packet,
  output logic                load_buffer_free,
  input  logic                fill_valid,
  input  mshr_idx_t           fill_mshr_idx,
  input  logic [63:0]         fill_data,
  output logic                ld_cdb_req,
  input  logic                ld_cdb_gnt,
  output prn_t                ld_wb_reg,
  output data_t               ld_wb_data,
  output b_mask_t             ld_wb_bm,
  input  b_mask_t             b_mm_resolve,
  input  logic                b_mm_mispred
);

  localparam int IDX_W = $clog2(DEPTH);

  // Fill merge: only still-missing bytes take fill data, so forwarded
  // store bytes survive. The word within the doubleword is load_addr[2].
  function automatic load_buffer_packet_t merge_fill(
    input load_buffer_packet_t p,
    input logic                fv,
    input mshr_idx_t           fidx,
    input logic [63:0]         fdata
  );
    load_buffer_packet_t q;
    data_t               w;
    q = p;
    w = p.load_addr[2] ? fdata[63:32] : fdata[31:0];
    if (fv && (p.mshr_idx == fidx)) begin
      for (int b = 0; b < 4; b++) begin
        if (p.byte_mask[b]) begin
          q.result[8*b +: 8] = w[8*b +: 8];
        end
      end
      q.byte_mask = '0;
    end
    return q;
  endfunction

  load_buffer_packet_t entry_reg  [DEPTH];
  load_buffer_packet_t entry_next [DEPTH];
  load_buffer_packet_t pkt_in;
  load_buffer_packet_t win_pkt;

  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] squash;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] alloc_onehot;
  logic             alloc_found;
  logic             enq;
  logic             deq;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  data_t            shifted;
  data_t            extended;
  logic             unused_sink;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign valid_vec[gi] = entry_reg[gi].valid;
      // A mispredicted entry drops out of select in the same cycle.
      assign squash[gi] = entry_reg[gi].valid && b_mm_mispred &&
                          (|(entry_reg[gi].bm & b_mm_resolve));
      assign ready[gi]  = entry_reg[gi].valid && (entry_reg[gi].byte_mask == 4'b0) &&
                          !squash[gi];
      assign kill[gi]   = squash[gi] || (deq && (win_idx == IDX_W'(gi)));
    end
  endgenerate

  // Free depends on registered state only, so a grant frees a slot next cycle.
  assign load_buffer_free = ~&valid_vec;
  assign enq              = load_buffer_packet.valid && load_buffer_free;
  assign deq              = ld_cdb_gnt && win_found;

  always_comb begin
    alloc_onehot = '0;
    alloc_found  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !alloc_found) begin
        alloc_onehot[i] = 1'b1;
        alloc_found     = 1'b1;
      end
    end
  end

  // Incoming packet is already squash-filtered upstream; only clear the
  // resolving bit, then merge any fill arriving in the same cycle.
  always_comb begin
    pkt_in    = load_buffer_packet;
    pkt_in.bm = load_buffer_packet.bm & ~b_mm_resolve;
    pkt_in    = merge_fill(pkt_in, fill_valid, fill_mshr_idx, fill_data);
  end

`ifdef LOAD_BUFFER_AGE_ORDER_EN
  // older_reg[j][i] = 1 means entry j was allocated before entry i.
  logic [DEPTH-1:0] older_reg  [DEPTH];
  logic [DEPTH-1:0] older_next [DEPTH];
  logic             blocked;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    blocked   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && older_reg[j][i]) blocked = 1'b1;
      end
      if (ready[i] && !blocked && !win_found) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) older_next[i] = older_reg[i];
    for (int i = 0; i < DEPTH; i++) begin
      if (kill[i]) begin
        older_next[i] = '0;
        for (int j = 0; j < DEPTH; j++) older_next[j][i] = 1'b0;
      end
    end
    // New entry is younger than every entry that survives this edge.
    for (int k = 0; k < DEPTH; k++) begin
      if (enq && alloc_onehot[k]) begin
        older_next[k] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          older_next[j][k] = valid_vec[j] && !kill[j];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= older_next[i];
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // Enqueue, fill merge, grant and branch resolve all land on the same edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_next[i]       = entry_reg[i];
      entry_next[i].valid = entry_reg[i].valid && !kill[i];
      entry_next[i].bm    = entry_reg[i].bm & ~b_mm_resolve;
      entry_next[i]       = merge_fill(entry_next[i], fill_valid, fill_mshr_idx, fill_data);
      if (enq && alloc_onehot[i]) begin
        entry_next[i]       = pkt_in;
        entry_next[i].valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
    end
  end

  // Align and extend the winner.
  assign win_pkt = entry_reg[win_idx];
  assign shifted = win_pkt.result >> {win_pkt.load_addr[1:0], 3'b000};

  always_comb begin
    case (win_pkt.load_func.size)
      MEM_BYTE: extended = win_pkt.load_func.is_unsigned ? {24'b0, shifted[7:0]}
                                                         : {{24{shifted[7]}}, shifted[7:0]};
      MEM_HALF: extended = win_pkt.load_func.is_unsigned ? {16'b0, shifted[15:0]}
                                                         : {{16{shifted[15]}}, shifted[15:0]};
      default:  extended = shifted;
    endcase
  end

  assign ld_cdb_req = win_found;
  assign ld_wb_reg  = win_found ? win_pkt.dest_reg_idx : '0;
  assign ld_wb_data = win_found ? extended : '0;
  assign ld_wb_bm   = win_found ? (win_pkt.bm & ~b_mm_resolve) : '0;

  assign unused_sink = ^{win_pkt.valid, win_pkt.mshr_idx, win_pkt.byte_mask,
                         win_pkt.load_addr[31:3]};

endmodule

// File: tb/tb_load_buffer.sv
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic                clock;
  logic                reset;
  load_buffer_packet_t pkt;
  logic                load_buffer_free;
  logic                fill_valid;
  mshr_idx_t           fill_mshr_idx;
  logic [63:0]         fill_data;
  logic                ld_cdb_req;
  logic                ld_cdb_gnt;
  prn_t                ld_wb_reg;
  data_t               ld_wb_data;
  b_mask_t             ld_wb_bm;
  b_mask_t             b_mm_resolve;
  logic                b_mm_mispred;

  int tests = 0;
  int fails = 0;

  load_buffer #(.DEPTH(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .load_buffer_packet (pkt),
    .load_buffer_free   (load_buffer_free),
    .fill_valid         (fill_valid),
    .fill_mshr_idx      (fill_mshr_idx),
    .fill_data          (fill_data),
    .ld_cdb_req         (ld_cdb_req),
    .ld_cdb_gnt         (ld_cdb_gnt),
    .ld_wb_reg          (ld_wb_reg),
    .ld_wb_data         (ld_wb_data),
    .ld_wb_bm           (ld_wb_bm),
    .b_mm_resolve       (b_mm_resolve),
    .b_mm_mispred       (b_mm_mispred)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pkt          = '0;
    fill_valid   = 1'b0;
    fill_mshr_idx = '0;
    fill_data    = '0;
    ld_cdb_gnt   = 1'b0;
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
  endtask

  function automatic load_buffer_packet_t mk(
    input mshr_idx_t m, input b_mask_t bm, input prn_t d, input logic [31:0] a,
    input mem_size_e sz, input logic u, input data_t r, input logic [3:0] msk
  );
    load_buffer_packet_t p;
    p.valid                 = 1'b1;
    p.mshr_idx              = m;
    p.bm                    = bm;
    p.dest_reg_idx          = d;
    p.load_addr             = a;
    p.load_func.size        = sz;
    p.load_func.is_unsigned = u;
    p.result                = r;
    p.byte_mask             = msk;
    return p;
  endfunction

  // Enqueue one resolved packet, check writeback next cycle, then grant it.
  task automatic resolved_load(input string tag, input logic [31:0] a, input mem_size_e sz,
                               input logic u, input data_t r, input data_t exp);
    pkt = mk(2'd0, 4'b0, 6'd9, a, sz, u, r, 4'b0);
    tick(); idle(); #1;
    $display("[TB] txn %s addr=%0h result=%0h", tag, a, r);
    chk({tag, "_req"}, ld_cdb_req, 1'b1);
    chk({tag, "_data"}, ld_wb_data, exp);
    ld_cdb_gnt = 1'b1;
    tick(); idle(); #1;
  endtask

  prn_t drain_order [4];

  initial begin
    reset = 1'b0;
    idle();
    #3;
    $display("[TB] txn reset");
    chk("rst_free", load_buffer_free, 1'b1);
    chk("rst_req",  ld_cdb_req, 1'b0);
    chk("rst_reg",  ld_wb_reg, 6'd0);
    chk("rst_data", ld_wb_data, 32'd0);
    chk("rst_bm",   ld_wb_bm, 4'd0);
    #9 reset = 1'b1;

    // Resolved LW, 1-cycle latency.
    tick();
    pkt = mk(2'd0, 4'b0, 6'd5, 32'h1000, MEM_WORD, 1'b0, 32'hDEADBEEF, 4'b0);
    tick(); idle(); #1;
    $display("[TB] txn resolved LW dest 5");
    chk("lw_req",  ld_cdb_req, 1'b1);
    chk("lw_reg",  ld_wb_reg, 6'd5);
    chk("lw_data", ld_wb_data, 32'hDEADBEEF);
    ld_cdb_gnt = 1'b1;
    tick(); idle(); #1;
    chk("lw_empty", ld_cdb_req, 1'b0);

    // LB signed / unsigned waiting on MSHR 2.
    for (int u = 0; u < 2; u++) begin
      pkt = mk(2'd2, 4'b0, 6'd7, 32'h1003, MEM_BYTE, u[0], 32'h00112233, 4'b1000);
      tick(); idle(); #1;
      chk("lb_wait", ld_cdb_req, 1'b0);
      fill_valid = 1'b1; fill_mshr_idx = 2'd1; fill_data = 64'h80CCCCCC_80555555;
      tick(); idle(); #1;
      chk("lb_wrong_mshr", ld_cdb_req, 1'b0);
      fill_valid = 1'b1; fill_mshr_idx = 2'd2; fill_data = 64'h80CCCCCC_80555555;
      tick(); idle(); #1;
      $display("[TB] txn LB unsigned=%0d filled", u);
      chk("lb_req",  ld_cdb_req, 1'b1);
      chk("lb_data", ld_wb_data, (u == 0) ? 32'hFFFFFF80 : 32'h00000080);
      ld_cdb_gnt = 1'b1;
      tick(); idle(); #1;
    end

    // Upper word select via load_addr[2].
    pkt = mk(2'd3, 4'b0, 6'd8, 32'h1004, MEM_WORD, 1'b0, 32'h0, 4'b1111);
    tick(); idle();
    fill_valid = 1'b1; fill_mshr_idx = 2'd3; fill_data = 64'h12345678_9ABCDEF0;
    tick(); idle(); #1;
    $display("[TB] txn LW upper word fill");
    chk("wsel_data", ld_wb_data, 32'h12345678);
    ld_cdb_gnt = 1'b1;
    tick(); idle(); #1;

    // Enqueue and fill in the same cycle; forwarded bytes kept.
    pkt = mk(2'd1, 4'b0, 6'd3, 32'h2000, MEM_WORD, 1'b0, 32'hAABB0000, 4'b0011);
    fill_valid = 1'b1; fill_mshr_idx = 2'd1; fill_data = 64'h00000000_FFFF1122;
    tick(); idle(); #1;
    $display("[TB] txn enqueue+fill same cycle");
    chk("same_req",  ld_cdb_req, 1'b1);
    chk("same_data", ld_wb_data, 32'hAABB1122);
    ld_cdb_gnt = 1'b1;
    tick(); idle(); #1;

    // Alignment / extension of resolved loads.
    resolved_load("lh_s",  32'h1002, MEM_HALF, 1'b0, 32'h80015555, 32'hFFFF8001);
    resolved_load("lh_u",  32'h1002, MEM_HALF, 1'b1, 32'h80015555, 32'h00008001);
    resolved_load("lb_b1", 32'h1001, MEM_BYTE, 1'b0, 32'h00007F00, 32'h0000007F);

    // Fill to DEPTH, drop while full, free after grant, re-enqueue.
    for (int i = 0; i < 4; i++) begin
      pkt = mk(2'd0, 4'b0, prn_t'(10 + i), 32'h0, MEM_WORD, 1'b0, 32'(i), 4'b0);
      tick(); idle();
    end
    #1;
    $display("[TB] txn buffer full");
    chk("full_free", load_buffer_free, 1'b0);
    chk("full_reg",  ld_wb_reg, 6'd10);
    pkt = mk(2'd0, 4'b0, 6'd20, 32'h0, MEM_WORD, 1'b0, 32'h0, 4'b0);
    ld_cdb_gnt = 1'b1;
    tick(); idle(); #1;
    chk("freed_free", load_buffer_free, 1'b1);
    chk("freed_reg",  ld_wb_reg, 6'd11);
    pkt = mk(2'd0, 4'b0, 6'd21, 32'h0, MEM_WORD, 1'b0, 32'h0, 4'b0);
    tick(); idle(); #1;
    chk("refull_free", load_buffer_free, 1'b0);
`ifdef LOAD_BUFFER_AGE_ORDER_EN
    drain_order = '{6'd11, 6'd12, 6'd13, 6'd21};
`else
    drain_order = '{6'd21, 6'd11, 6'd12, 6'd13};
`endif
    for (int i = 0; i < 4; i++) begin
      $display("[TB] txn drain %0d", i);
      chk("drain_reg", ld_wb_reg, drain_order[i]);
      ld_cdb_gnt = 1'b1;
      tick(); idle(); #1;
    end
    chk("drain_empty", ld_cdb_req, 1'b0);
    chk("drain_free",  load_buffer_free, 1'b1);

    // Mispredict squash: ready bm=01 entry dropped, waiting bm=10 entry kept.
    pkt = mk(2'd0, 4'b0001, 6'd30, 32'h3000, MEM_WORD, 1'b0, 32'h11111111, 4'b0);
    tick(); idle();
    pkt = mk(2'd0, 4'b0010, 6'd31, 32'h3000, MEM_WORD, 1'b0, 32'h0, 4'b1111);
    #1;
    chk("bm_a_reg", ld_wb_reg, 6'd30);
    chk("bm_a_bm",  ld_wb_bm, 4'b0001);
    tick(); idle();
    b_mm_resolve = 4'b0001; b_mm_mispred = 1'b1; ld_cdb_gnt = 1'b1;
    #1;
    $display("[TB] txn mispredict bm 0001");
    chk("squash_req", ld_cdb_req, 1'b0);
    tick(); idle(); #1;
    chk("squash_gone", ld_cdb_req, 1'b0);
    fill_valid = 1'b1; fill_mshr_idx = 2'd0; fill_data = 64'h0_CAFEF00D;
    tick(); idle(); #1;
    chk("keep_reg",  ld_wb_reg, 6'd31);
    chk("keep_bm",   ld_wb_bm, 4'b0010);
    chk("keep_data", ld_wb_data, 32'hCAFEF00D);
    b_mm_resolve = 4'b0010; ld_cdb_gnt = 1'b1;
    #1;
    chk("resolve_bm_clear", ld_wb_bm, 4'b0000);
    tick(); idle(); #1;
    chk("bm_empty", ld_cdb_req, 1'b0);

    // Resolve bit cleared on an incoming packet.
    pkt = mk(2'd0, 4'b0100, 6'd40, 32'h0, MEM_WORD, 1'b0, 32'h5, 4'b0);
    b_mm_resolve = 4'b0100;
    tick(); idle(); #1;
    $display("[TB] txn incoming resolve clear");
    chk("in_bm", ld_wb_bm, 4'b0000);
    chk("in_reg", ld_wb_reg, 6'd40);

    // Asynchronous reset discards the pending entry.
    #2 reset = 1'b0;
    #1;
    $display("[TB] txn async reset");
    chk("arst_req",  ld_cdb_req, 1'b0);
    chk("arst_free", load_buffer_free, 1'b1);
    chk("arst_data", ld_wb_data, 32'd0);
    #1 reset = 1'b1;
    tick(); #1;
    chk("arst_stay", ld_cdb_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
